// File: rtl/input_taker_gen_if.sv
// Handshake bundle for input_taker_gen: beat input side, frame output side and fill count.
// The master modport is the producer/consumer side; the slave modport is the collector.
interface input_taker_gen_if #(
    parameter int PT_W  = 4,
    parameter int KEY_W = 8,
    parameter int WORDS = 8
);
    localparam int CNT_W = $clog2(WORDS + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [PT_W-1:0]        pt_in;
    logic [KEY_W-1:0]       key_in;
    logic [PT_W*WORDS-1:0]  data;
    logic [KEY_W*WORDS-1:0] key_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [CNT_W-1:0]       count;

    modport master (
        output in_valid, pt_in, key_in, out_ready,
        input  in_ready, data, key_out, out_valid, count
    );

    modport slave (
        input  in_valid, pt_in, key_in, out_ready,
        output in_ready, data, key_out, out_valid, count
    );
endinterface

// File: rtl/input_taker_gen.sv
// Collects WORDS plaintext/key beats into a frame, then holds it until the consumer takes it.
// Optional macro INPUT_TAKER_ABORT_EN adds an abort input that drops the frame in progress.
module input_taker_gen #(
    parameter int PT_W  = 4,
    parameter int KEY_W = 8,
    parameter int WORDS = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef INPUT_TAKER_ABORT_EN
    input  logic abort,
`endif
    input_taker_gen_if.slave bus
);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PT_W-1:0]    pt_slot_q  [WORDS];
    logic [PT_W-1:0]    pt_slot_d  [WORDS];
    logic [KEY_W-1:0]   key_slot_q [WORDS];
    logic [KEY_W-1:0]   key_slot_d [WORDS];

    logic               in_ready_w;
    logic               out_valid_w;
    logic               abort_w;
    logic               accept_w;
    logic [IDX_W-1:0]   slot_idx;

`ifdef INPUT_TAKER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept_w = bus.in_valid && in_ready_w;
    assign slot_idx = count_q[IDX_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            count_q <= '0;
            for (int i = 0; i < WORDS; i++) begin
                pt_slot_q[i]  <= '0;
                key_slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pt_slot_q  <= pt_slot_d;
            key_slot_q <= key_slot_d;
        end
    end

    // Abort outranks both a beat and the output handshake; slots are never cleared here.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pt_slot_d  = pt_slot_q;
        key_slot_d = key_slot_q;
        if (abort_w) begin
            state_d = COLLECT;
            count_d = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept_w) begin
                        pt_slot_d[slot_idx]  = bus.pt_in;
                        key_slot_d[slot_idx] = bus.key_in;
                        count_d              = count_q + CNT_W'(1);
                        if (count_q == LAST_IDX) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_d = COLLECT;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready_w  = (state_q == COLLECT);
        out_valid_w = (state_q == FULL);
    end

    wire [PT_W*WORDS-1:0]  data_w;
    wire [KEY_W*WORDS-1:0] key_w;

    // Slot 0 occupies the most significant word of each packed output.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
            assign data_w[PT_W*(WORDS-gi)-1 -: PT_W]  = pt_slot_q[gi];
            assign key_w[KEY_W*(WORDS-gi)-1 -: KEY_W] = key_slot_q[gi];
        end
    endgenerate

    assign bus.data      = data_w;
    assign bus.key_out   = key_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_input_taker_gen.sv
// Directed bench for input_taker_gen: stimulus queues expected frames, a monitor checks each presented frame.
// Also exercises the abort input when INPUT_TAKER_ABORT_EN is defined.
module tb_input_taker_gen;
    localparam int PT_W  = 4;
    localparam int KEY_W = 8;
    localparam int WORDS = 8;

    typedef struct packed {
        logic [31:0] d;
        logic [63:0] k;
    } frame_t;

    logic clk;
    logic reset;
`ifdef INPUT_TAKER_ABORT_EN
    logic abort;
`endif

    int total;
    int bad;
    frame_t exp_q[$];

    input_taker_gen_if #(.PT_W(PT_W), .KEY_W(KEY_W), .WORDS(WORDS)) bus ();

    input_taker_gen #(.PT_W(PT_W), .KEY_W(KEY_W), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef INPUT_TAKER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic send_beat(input logic [PT_W-1:0] p, input logic [KEY_W-1:0] k, output int waits);
        waits = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.pt_in    = p;
        bus.key_in   = k;
        while (!bus.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 20) chk("beat_timeout", 64'(waits), 64'd0);
        @(posedge clk);
        $display("beat pt=0x%0h key=0x%0h waits=%0d", p, k, waits);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every cycle a frame is presented it must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    chk("frame_data", 64'(bus.data), 64'(exp_q[0].d));
                    chk("frame_key", bus.key_out, exp_q[0].k);
                    chk("frame_count", 64'(bus.count), 64'd8);
                    if (bus.out_ready) begin
                        $display("frame taken data=0x%0h key=0x%0h", bus.data, bus.key_out);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.pt_in     = '0;
        bus.key_in    = '0;
        bus.out_ready = 1'b1;
`ifdef INPUT_TAKER_ABORT_EN
        abort = 1'b0;
`endif
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_data", 64'(bus.data), 64'd0);
        chk("rst_key", bus.key_out, 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        // Eight consecutive beats, consumer always ready.
        exp_q.push_back('{d: 32'h12345678, k: 64'h1122334455667788});
        for (int i = 0; i < WORDS; i++) send_beat(PT_W'(i + 1), KEY_W'((i + 1) * 8'h11), w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_count", 64'(bus.count), 64'd8);
        @(negedge clk);
        #1;
        chk("back_out_valid", 64'(bus.out_valid), 64'd0);
        chk("back_count", 64'(bus.count), 64'd0);
        chk("back_in_ready", 64'(bus.in_ready), 64'd1);

        // Back-pressure: frame held for five cycles while in_valid stays high.
        bus.out_ready = 1'b0;
        exp_q.push_back('{d: 32'h12345678, k: 64'h1122334455667788});
        for (int i = 0; i < WORDS; i++) send_beat(PT_W'(i + 1), KEY_W'((i + 1) * 8'h11), w);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.pt_in    = 4'hF;
            bus.key_in   = 8'hEE;
            #1;
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("release_count", 64'(bus.count), 64'd0);
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);

        // Gapped input: each beat followed by two idle cycles.
        exp_q.push_back('{d: 32'h12345678, k: 64'h1122334455667788});
        for (int i = 0; i < WORDS; i++) begin
            send_beat(PT_W'(i + 1), KEY_W'((i + 1) * 8'h11), w);
            for (int g = 0; g < 2; g++) begin
                idle_cycle();
                #1;
                if (i < WORDS - 1) chk("gap_count", 64'(bus.count), 64'(i + 1));
            end
        end

        // Two back-to-back frames: exactly one bubble, second frame overwrites every slot.
        exp_q.push_back('{d: 32'h12345678, k: 64'h1122334455667788});
        exp_q.push_back('{d: 32'h87654321, k: 64'h8172635445362718});
        for (int i = 0; i < WORDS; i++) send_beat(PT_W'(i + 1), KEY_W'((i + 1) * 8'h11), w);
        for (int i = 0; i < WORDS; i++) begin
            send_beat(PT_W'(8 - i), {4'(8 - i), 4'(i + 1)}, w);
            if (i == 0) chk("bubble_waits", 64'(w), 64'd1);
        end
        idle_cycle();
        idle_cycle();

        // Asynchronous reset between edges after three beats.
        for (int i = 0; i < 3; i++) send_beat(PT_W'(i + 1), KEY_W'((i + 1) * 8'h11), w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_data", 64'(bus.data), 64'd0);
        chk("arst_key", bus.key_out, 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        #1 reset = 1'b0;
        exp_q.push_back('{d: 32'hFEDCBA98, k: 64'hFFEEDDCCBBAA9988});
        for (int i = 0; i < WORDS; i++) send_beat(PT_W'(15 - i), {4'(15 - i), 4'(15 - i)}, w);
        idle_cycle();

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("drain_pending", 64'(exp_q.size()), 64'd0);
        end

`ifdef INPUT_TAKER_ABORT_EN
        // Abort after five beats with a beat offered in the same cycle.
        for (int i = 0; i < 5; i++) send_beat(PT_W'(i + 1), KEY_W'((i + 1) * 8'h11), w);
        @(negedge clk);
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        bus.pt_in    = 4'h6;
        bus.key_in   = 8'h66;
        @(negedge clk);
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("abort_count", 64'(bus.count), 64'd0);
        chk("abort_data", 64'(bus.data), 64'h12345A98);
        chk("abort_key", bus.key_out, 64'h1122334455AA9988);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
